// File: rtl/alu_ctrl_q.sv
// WISC-SP22 ALU control decoder feeding a 2-entry skid FIFO with HALT blocking.
// Define ALU_CTRL_PERF_EN to build the saturating issue/stall performance counters.
module alu_ctrl_q (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        add,
  output logic        x_or,
  output logic        and_,
  output logic        shift_rotate,
  output logic        left_right,
  output logic        btr,
  output logic        slbi,
  output logic        lbi,
  output logic        branch,
  output logic        invA,
  output logic        invB,
  output logic        Cin,
  output logic        sign,
  output logic        halt_op,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int BW     = 14;
  localparam int B_ADD  = 13;
  localparam int B_XOR  = 12;
  localparam int B_AND  = 11;
  localparam int B_SR   = 10;
  localparam int B_LR   = 9;
  localparam int B_BTR  = 8;
  localparam int B_SLBI = 7;
  localparam int B_LBI  = 6;
  localparam int B_BR   = 5;
  localparam int B_INVA = 4;
  localparam int B_INVB = 3;
  localparam int B_CIN  = 2;
  localparam int B_SIGN = 1;
  localparam int B_HALT = 0;

  state_t        state_reg, state_next;
  logic          halted_reg, halted_next;
  logic [BW-1:0] head_reg, head_next;
  logic [BW-1:0] tail_reg, tail_next;
  logic [BW-1:0] dec_bundle;
  logic [BW-1:0] head_out;
  logic [4:0]    opcode;
  logic [1:0]    func;
  logic          push, pop;
  logic          unused_instr_bits;

  assign opcode            = instr[15:11];
  assign func              = instr[1:0];
  assign unused_instr_bits = ^instr[10:2];

  always_comb begin
    dec_bundle = '0;
    case (opcode)
      5'b00000: dec_bundle[B_HALT] = 1'b1;
      5'b01000, 5'b10000, 5'b10001, 5'b10011, 5'b11111:
        dec_bundle[B_ADD] = 1'b1;
      5'b01001: begin
        dec_bundle[B_ADD]  = 1'b1;
        dec_bundle[B_INVA] = 1'b1;
        dec_bundle[B_CIN]  = 1'b1;
      end
      5'b01010: dec_bundle[B_XOR] = 1'b1;
      5'b01011: begin
        dec_bundle[B_AND]  = 1'b1;
        dec_bundle[B_INVB] = 1'b1;
      end
      5'b10100: dec_bundle[B_LR] = 1'b1;
      5'b10101: begin
        dec_bundle[B_SR] = 1'b1;
        dec_bundle[B_LR] = 1'b1;
      end
      5'b10110: dec_bundle = '0;
      5'b10111: dec_bundle[B_SR] = 1'b1;
      5'b11011: begin
        // Register-format arithmetic: func selects ADD/SUB/XOR/ANDN
        case (func)
          2'b00: dec_bundle[B_ADD] = 1'b1;
          2'b01: begin
            dec_bundle[B_ADD]  = 1'b1;
            dec_bundle[B_INVA] = 1'b1;
            dec_bundle[B_CIN]  = 1'b1;
          end
          2'b10: dec_bundle[B_XOR] = 1'b1;
          default: begin
            dec_bundle[B_AND]  = 1'b1;
            dec_bundle[B_INVB] = 1'b1;
          end
        endcase
      end
      5'b11010: begin
        case (func)
          2'b00: dec_bundle[B_LR] = 1'b1;
          2'b01: begin
            dec_bundle[B_SR] = 1'b1;
            dec_bundle[B_LR] = 1'b1;
          end
          2'b10: dec_bundle = '0;
          default: dec_bundle[B_SR] = 1'b1;
        endcase
      end
      5'b11001: dec_bundle[B_BTR] = 1'b1;
      5'b10010: dec_bundle[B_SLBI] = 1'b1;
      5'b11000: begin
        dec_bundle[B_LBI] = 1'b1;
        dec_bundle[B_ADD] = 1'b1;
      end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
        dec_bundle[B_BR]  = 1'b1;
        dec_bundle[B_ADD] = 1'b1;
      end
      5'b11100, 5'b11101, 5'b11110: begin
        dec_bundle[B_ADD]  = 1'b1;
        dec_bundle[B_INVB] = 1'b1;
        dec_bundle[B_CIN]  = 1'b1;
        dec_bundle[B_SIGN] = 1'b1;
      end
      default: dec_bundle = '0;
    endcase
  end

  assign in_ready  = (state_reg != FULL) & ~halted_reg;
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next  = state_reg;
    halted_next = halted_reg;
    head_next   = head_reg;
    tail_next   = tail_reg;
    if (flush) begin
      state_next  = EMPTY;
      halted_next = 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_next  = dec_bundle;
            state_next = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_next  = dec_bundle;
              state_next = FULL;
            end
            2'b01: state_next = EMPTY;
            2'b11: head_next = dec_bundle;
            default: state_next = ONE;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the queue
          if (pop) begin
            head_next  = tail_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
      if (push && dec_bundle[B_HALT]) halted_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= EMPTY;
      halted_reg <= 1'b0;
      head_reg   <= '0;
      tail_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= halted_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
    end
  end

  // Stale head contents must never leak out while the queue is empty
  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_head_gate
      assign head_out[gi] = head_reg[gi] & out_valid;
    end
  endgenerate

  assign add          = head_out[B_ADD];
  assign x_or         = head_out[B_XOR];
  assign and_         = head_out[B_AND];
  assign shift_rotate = head_out[B_SR];
  assign left_right   = head_out[B_LR];
  assign btr          = head_out[B_BTR];
  assign slbi         = head_out[B_SLBI];
  assign lbi          = head_out[B_LBI];
  assign branch       = head_out[B_BR];
  assign invA         = head_out[B_INVA];
  assign invB         = head_out[B_INVB];
  assign Cin          = head_out[B_CIN];
  assign sign         = head_out[B_SIGN];
  assign halt_op      = head_out[B_HALT];

`ifdef ALU_CTRL_PERF_EN
  logic [15:0] issue_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (pop && (issue_cnt_reg != 16'hFFFF))
        issue_cnt_reg <= issue_cnt_reg + 16'd1;
      if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign issue_cnt = issue_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  assign issue_cnt = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule
